// File: rtl/max_52_2_pkg.sv
// max_52_2_pkg
//   Shared widths and operand type for the max_52_2 block.
//   OPW : operand width (each half of pi)
//   PIW : packed input width (two operands)
//   POW : output width (max value plus select flag)
package max_52_2_pkg;

  localparam int OPW = 4;
  localparam int PIW = 8;
  localparam int POW = 5;

  typedef logic [OPW-1:0] operand_t;

endpackage

// File: rtl/max_52_2_cmp.sv
// max_52_2_cmp
//   Combinational unsigned max/select of two operands.
//   Ports:
//     a   : first operand (wins ties)
//     b   : second operand
//     max : larger of a and b
//     sel : 1 when b is strictly greater than a
module max_52_2_cmp
  import max_52_2_pkg::*;
(
  input  operand_t a,
  input  operand_t b,
  output operand_t max,
  output logic     sel
);

  assign sel = (b > a);
  assign max = sel ? b : a;

endmodule

// File: rtl/max_52_2.sv
// max_52_2
//   Registered max-of-two selector with an optional running peak tracker.
//   Optional feature macro: MAX_52_2_PEAK_EN (adds peak_clr/peak and the
//   peak register).
//   Ports:
//     clk       : rising-edge clock
//     rst_n     : asynchronous active-low reset
//     in_valid  : qualifies pi this cycle
//     pi        : {A, B}, two unsigned 4-bit operands
//     po        : {sel, max(A,B)}, registered, 1-cycle latency, holds when idle
//     peak_clr  : synchronous clear of the peak tracker (MAX_52_2_PEAK_EN)
//     peak      : running maximum since reset or clear (MAX_52_2_PEAK_EN)
//     out_valid : qualifies po
module max_52_2
  import max_52_2_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [PIW-1:0] pi,
  output logic [POW-1:0] po,
`ifdef MAX_52_2_PEAK_EN
  input  logic           peak_clr,
  output logic [OPW-1:0] peak,
`endif
  output logic           out_valid
);

  operand_t op_a;
  operand_t op_b;
  operand_t cur_max;
  logic     cur_sel;

  assign op_a = pi[PIW-1:OPW];
  assign op_b = pi[OPW-1:0];

  max_52_2_cmp u_cmp (
    .a   (op_a),
    .b   (op_b),
    .max (cur_max),
    .sel (cur_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      po        <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        po <= {cur_sel, cur_max};
      end
    end
  end

`ifdef MAX_52_2_PEAK_EN
  operand_t peak_upd;
  logic     peak_sel_unused;

  // Same comparator reused: the running peak only ever takes the larger of
  // itself and the new max, so it is bounded by 0xF and cannot wrap.
  max_52_2_cmp u_peak_cmp (
    .a   (peak),
    .b   (cur_max),
    .max (peak_upd),
    .sel (peak_sel_unused)
  );

  // A clear coinciding with a valid input restarts the peak at that input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak <= '0;
    end else if (peak_clr) begin
      peak <= in_valid ? cur_max : '0;
    end else if (in_valid) begin
      peak <= peak_upd;
    end
  end
`endif

endmodule

// File: tb/tb_max_52_2.sv
module tb_max_52_2;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] pi;
  logic [4:0] po;
  logic       out_valid;
  logic       peak_clr;
  logic [3:0] peak;

  int checks   = 0;
  int failures = 0;

  logic [4:0] po_q[$];
  logic [3:0] peak_q[$];
  logic [4:0] last_po;
  logic [3:0] peak_m;

  max_52_2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .pi        (pi),
    .po        (po),
`ifdef MAX_52_2_PEAK_EN
    .peak_clr  (peak_clr),
    .peak      (peak),
`endif
    .out_valid (out_valid)
  );

`ifndef MAX_52_2_PEAK_EN
  assign peak = 4'h0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: larger operand, A wins ties, flag set only when B is strictly larger.
  function automatic logic [4:0] ref_po(input logic [7:0] p);
    int a, b;
    a = int'(p[7:4]);
    b = int'(p[3:0]);
    if (b > a) return {1'b1, 4'(b)};
    return {1'b0, 4'(a)};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One input cycle: drive just after the edge, record the expected responses.
  task automatic drive(input logic v, input logic [7:0] p, input logic c);
    logic [3:0] mx;
    @(posedge clk);
    #1;
    in_valid = v;
    pi       = p;
    peak_clr = c;
    mx = ref_po(p) & 5'h0F;
    if (v) po_q.push_back(ref_po(p));
    if (c) peak_m = v ? mx : 4'h0;
    else if (v && mx > peak_m) peak_m = mx;
    peak_q.push_back(peak_m);
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    pi       = 8'hFF;
    peak_clr = 1'b0;
    po_q.delete();
    peak_q.delete();
    last_po = 5'h00;
    peak_m  = 4'h0;
    #1;
    check("async_rst_po", {3'b0, po}, 8'h00);
    check("async_rst_valid", {7'b0, out_valid}, 8'h00);
    repeat (cycles) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  // po/out_valid monitor: pops an expectation only when the DUT presents a result.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_po", {3'b0, po}, 8'h00);
      check("rst_out_valid", {7'b0, out_valid}, 8'h00);
    end else if (out_valid) begin
      if (po_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_out_valid actual=1 required=0 t=%0t", $time);
      end else begin
        last_po = po_q.pop_front();
        check("po", {3'b0, po}, {3'b0, last_po});
      end
    end else begin
      check("po_hold", {3'b0, po}, {3'b0, last_po});
    end
  end

`ifdef MAX_52_2_PEAK_EN
  // Peak monitor: one expectation per driven cycle, due after the sampling edge.
  int peak_avail;
  always begin
    @(posedge clk);
    peak_avail = peak_q.size();
    @(negedge clk);
    if (!rst_n) begin
      check("rst_peak", {4'b0, peak}, 8'h00);
    end else if (peak_avail > 0 && peak_q.size() > 0) begin
      check("peak", {4'b0, peak}, {4'b0, peak_q.pop_front()});
    end
  end
`endif

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    pi       = 8'hFF;
    peak_clr = 1'b0;
    last_po  = 5'h00;
    peak_m   = 4'h0;

    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;

    for (int i = 0; i < 256; i++) drive(1'b1, 8'(i), 1'b0);

    drive(1'b1, 8'h2A, 1'b0);
    repeat (3) drive(1'b0, $urandom_range(0, 255), 1'b0);

    drive(1'b1, 8'h12, 1'b0);
    drive(1'b1, 8'h90, 1'b0);
    drive(1'b1, 8'h34, 1'b0);
    drive(1'b1, 8'h21, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'hF0, 1'b0);
    drive(1'b1, 8'h0F, 1'b0);
    drive(1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 300; i++) begin
      drive(($urandom % 4) != 0, 8'($urandom), ($urandom % 16) == 0);
    end

    drive(1'b1, 8'h5E, 1'b0);
    drive(1'b1, 8'h73, 1'b0);
    apply_reset(2);
    drive(1'b1, 8'hC4, 1'b0);
    drive(1'b0, 8'h00, 1'b0);

    apply_reset(1);
    for (int i = 0; i < 40; i++) drive(1'b1, 8'($urandom), 1'b0);

    repeat (3) drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("po_queue_drained", 8'(po_q.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
